fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode_stage.
- Owns the PC register and the IMEM address, and the IF/ID pipeline register (instruction, PC+4, valid).
- Handles stall, branch/jump redirect with flush, and SYS_load PC preload.
- Also provides a fetched-instruction counter and a sticky misalignment flag for SYS_leds debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word aligned)
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) written to IF/ID on flush or bubble
CNT_WIDTH, 32, width of fetched-instruction counter

Ports:
SYS_clk  in  1  system clock; all state updates on falling edge (negedge), matching the rest of the pipeline
SYS_reset  in  1  asynchronous, active-low reset
SYS_load  in  1  level: hold fetch and preload PC from SYS_pc_val
SYS_pc_val  in  8  word index for preload; PC = {22'b0, SYS_pc_val, 2'b00}
F_stall  in  1  hazard-unit stall: hold PC and IF/ID contents
F_redirect  in  1  taken branch/jump resolved downstream
F_redirect_target  in  32  byte-address target for F_redirect
F_imem_instruction  in  32  combinational IMEM read data for F_pc
F_pc  out  32  current fetch address to IMEM
D_instruction  out  32  IF/ID instruction to decode_stage
D_pc_plus4  out  32  IF/ID PC+4 of D_instruction
D_valid  out  1  1 = D_instruction is a real fetched instruction
F_fetch_count  out  CNT_WIDTH  number of instructions accepted into IF/ID
F_misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset (SYS_reset=0, async):
  - F_pc=RESET_PC, D_instruction=NOP_INSTR, D_pc_plus4=0, D_valid=0.
  - F_fetch_count=0, F_misalign_err=0, state=IDLE.
- FSM states: IDLE, LOAD, RUN, HOLD. Evaluated each negedge after reset release.
  - IDLE: one bubble edge. PC unchanged, IF/ID gets NOP with valid 0. Next state LOAD if SYS_load, else RUN.
  - LOAD: while SYS_load=1, F_pc<=SYS_pc_val<<2 each edge, IF/ID gets NOP with valid 0. When SYS_load=0, go to RUN with PC unchanged.
  - RUN and HOLD share one priority order per edge:
    1. SYS_load=1: go to LOAD, F_pc<=SYS_pc_val<<2, IF/ID NOP.
    2. F_redirect=1: F_pc<={target[31:2],2'b00}; IF/ID NOP, valid 0; state RUN. Overrides F_stall.
    3. F_stall=1: F_pc and IF/ID hold; state HOLD.
    4. Otherwise: IF/ID<={F_imem_instruction, F_pc+4, valid 1}; F_pc<=F_pc+4; state RUN.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- F_fetch_count increments only on case 4. Wraps modulo 2^CNT_WIDTH.
- F_misalign_err sets when F_redirect=1 and target[1:0]!=0, in any state that accepts the redirect. Cleared only by reset.
- Latency: instruction at F_pc appears on D_instruction one negedge later.
- Redirect during stall: flush wins; the stalled IF/ID content is discarded.
- Reset asserted mid-stall or mid-load returns every output to its reset value immediately, independent of the clock.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP_INSTR.
  - Fetch state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HOLD=2'd3).
  - PC_INC=4.
- One natural sub-module, if_id_reg: the IF/ID register with stall-hold and flush-to-NOP. The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset with RESET_PC=0, release, IMEM[0]=32'h0123_4020 -> first edge bubble (D_valid=0); next edge D_instruction=32'h0123_4020, D_pc_plus4=4, F_pc=8 after the following edge, count=1.
- F_stall=1 for 3 edges at F_pc=0x10 -> F_pc stays 0x10, D_* unchanged, count unchanged; after release the fetch resumes at 0x10.
- F_redirect=1, target=0x40, with F_stall=1 -> next edge F_pc=0x40, D_valid=0, D_instruction=NOP_INSTR; next edge fetches IMEM[0x40].
- F_redirect=1, target=0x43 -> F_pc=0x40, F_misalign_err=1, and it stays 1 through later redirects until reset.
- SYS_load=1, SYS_pc_val=8'h05 for 2 edges, then release -> F_pc=0x14, D_valid=0 throughout; the first valid D_pc_plus4 is 0x18.
- Assert SYS_reset=0 between edges during a HOLD -> outputs immediately at reset values; F_pc starting at 32'hFFFF_FFFC without reset -> wraps to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline stages.
// Fetch state encoding, bubble instruction and PC increment.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to NOP bubble, capture a fetched instruction, or hold.
// Updates on the falling clock edge like the rest of the pipeline.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] BUBBLE = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Flush outranks load so a redirect always discards whatever was captured.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= BUBBLE;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= BUBBLE;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM, IF/ID register and debug counters.
//
// state | meaning
// IDLE  | one bubble edge after reset release
// LOAD  | SYS_load held: PC preloaded from SYS_pc_val, IF/ID bubbles
// RUN   | normal fetch, one instruction per edge
// HOLD  | hazard stall: PC and IF/ID frozen
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 SYS_load,
    input  logic [7:0]           SYS_pc_val,
    input  logic                 F_stall,
    input  logic                 F_redirect,
    input  logic [31:0]          F_redirect_target,
    input  logic [31:0]          F_imem_instruction,
    output logic [31:0]          F_pc,
    output logic [31:0]          D_instruction,
    output logic [31:0]          D_pc_plus4,
    output logic                 D_valid,
    output logic [CNT_WIDTH-1:0] F_fetch_count,
    output logic                 F_misalign_err
);

    fetch_state_t state, state_next;

    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] preload_pc;
    logic        ifid_flush;
    logic        ifid_load;
    logic        count_inc;
    logic        misalign_set;

    assign pc_inc     = F_pc + PC_INC;
    assign preload_pc = {22'b0, SYS_pc_val, 2'b00};

    always_ff @(negedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state          <= ST_IDLE;
            F_pc           <= RESET_PC;
            F_fetch_count  <= '0;
            F_misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            F_pc  <= pc_next;
            if (count_inc) begin
                F_fetch_count <= F_fetch_count + CNT_WIDTH'(1);
            end
            if (misalign_set) begin
                F_misalign_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE,
            ST_LOAD: state_next = SYS_load ? ST_LOAD : ST_RUN;
            ST_RUN,
            ST_HOLD: begin
                if (SYS_load)        state_next = ST_LOAD;
                else if (F_redirect) state_next = ST_RUN;
                else if (F_stall)    state_next = ST_HOLD;
                else                 state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_next      = F_pc;
        ifid_flush   = 1'b0;
        ifid_load    = 1'b0;
        count_inc    = 1'b0;
        misalign_set = 1'b0;
        case (state)
            ST_IDLE: ifid_flush = 1'b1;
            ST_LOAD: begin
                ifid_flush = 1'b1;
                if (SYS_load) pc_next = preload_pc;
            end
            ST_RUN,
            ST_HOLD: begin
                if (SYS_load) begin
                    pc_next    = preload_pc;
                    ifid_flush = 1'b1;
                end else if (F_redirect) begin
                    // Redirect beats stall; low target bits are dropped and flagged.
                    pc_next      = {F_redirect_target[31:2], 2'b00};
                    ifid_flush   = 1'b1;
                    misalign_set = |F_redirect_target[1:0];
                end else if (!F_stall) begin
                    pc_next   = pc_inc;
                    ifid_load = 1'b1;
                    count_inc = 1'b1;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    if_id_reg #(
        .BUBBLE(NOP_INSTR)
    ) u_if_id_reg (
        .clk        (SYS_clk),
        .rst_n      (SYS_reset),
        .flush      (ifid_flush),
        .load       (ifid_load),
        .instr_in   (F_imem_instruction),
        .pc_plus4_in(pc_inc),
        .instr      (D_instruction),
        .pc_plus4   (D_pc_plus4),
        .valid      (D_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small word-indexed IMEM model.
module tb_fetch_stage;

    logic        SYS_clk;
    logic        SYS_reset;
    logic        SYS_load;
    logic [7:0]  SYS_pc_val;
    logic        F_stall;
    logic        F_redirect;
    logic [31:0] F_redirect_target;
    logic [31:0] F_imem_instruction;
    logic [31:0] F_pc;
    logic [31:0] D_instruction;
    logic [31:0] D_pc_plus4;
    logic        D_valid;
    logic [31:0] F_fetch_count;
    logic        F_misalign_err;

    logic [31:0] imem [64];
    int          errors = 0;
    int          checks = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000),
        .CNT_WIDTH(32)
    ) dut (
        .SYS_clk           (SYS_clk),
        .SYS_reset         (SYS_reset),
        .SYS_load          (SYS_load),
        .SYS_pc_val        (SYS_pc_val),
        .F_stall           (F_stall),
        .F_redirect        (F_redirect),
        .F_redirect_target (F_redirect_target),
        .F_imem_instruction(F_imem_instruction),
        .F_pc              (F_pc),
        .D_instruction     (D_instruction),
        .D_pc_plus4        (D_pc_plus4),
        .D_valid           (D_valid),
        .F_fetch_count     (F_fetch_count),
        .F_misalign_err    (F_misalign_err)
    );

    assign F_imem_instruction = imem[F_pc[7:2]];

    initial SYS_clk = 1'b1;
    always #5 SYS_clk = ~SYS_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one active (falling) edge and settle between edges.
    task automatic tick();
        @(negedge SYS_clk);
        #2;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic vld);
        chk({tag, ".instr"}, D_instruction, instr);
        chk({tag, ".pc4"}, D_pc_plus4, pc4);
        chk({tag, ".valid"}, {31'b0, D_valid}, {31'b0, vld});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;
        imem[0] = 32'h0123_4020;

        SYS_reset = 1'b0;
        SYS_load = 1'b0;
        SYS_pc_val = 8'h00;
        F_stall = 1'b0;
        F_redirect = 1'b0;
        F_redirect_target = 32'h0;
        #1;
        chk("rst.pc", F_pc, 32'h0);
        chk_d("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.count", F_fetch_count, 32'd0);
        chk("rst.err", {31'b0, F_misalign_err}, 32'd0);
        tick();
        tick();
        SYS_reset = 1'b1;

        // IDLE bubble edge
        tick();
        chk("idle.pc", F_pc, 32'h0);
        chk("idle.valid", {31'b0, D_valid}, 32'd0);

        tick();
        chk_d("run0", 32'h0123_4020, 32'h4, 1'b1);
        chk("run0.pc", F_pc, 32'h4);
        chk("run0.count", F_fetch_count, 32'd1);
        tick();
        chk("run1.pc", F_pc, 32'h8);
        chk("run1.instr", D_instruction, 32'h1000_0001);
        tick();
        tick();
        chk_d("run3", 32'h1000_0003, 32'h10, 1'b1);
        chk("run3.pc", F_pc, 32'h10);
        chk("run3.count", F_fetch_count, 32'd4);

        // three stalled edges
        F_stall = 1'b1;
        tick();
        tick();
        tick();
        chk("stall.pc", F_pc, 32'h10);
        chk_d("stall", 32'h1000_0003, 32'h10, 1'b1);
        chk("stall.count", F_fetch_count, 32'd4);
        F_stall = 1'b0;
        tick();
        chk_d("resume", 32'h1000_0004, 32'h14, 1'b1);
        chk("resume.pc", F_pc, 32'h14);
        chk("resume.count", F_fetch_count, 32'd5);

        // redirect while stalled: flush wins
        F_stall = 1'b1;
        tick();
        F_redirect = 1'b1;
        F_redirect_target = 32'h40;
        tick();
        chk("redir.pc", F_pc, 32'h40);
        chk("redir.instr", D_instruction, 32'h0);
        chk("redir.valid", {31'b0, D_valid}, 32'd0);
        chk("redir.count", F_fetch_count, 32'd5);
        chk("redir.err", {31'b0, F_misalign_err}, 32'd0);
        F_stall = 1'b0;
        F_redirect = 1'b0;
        tick();
        chk_d("tgt", 32'h1000_0010, 32'h44, 1'b1);
        chk("tgt.pc", F_pc, 32'h44);
        chk("tgt.count", F_fetch_count, 32'd6);

        // misaligned redirect
        F_redirect = 1'b1;
        F_redirect_target = 32'h43;
        tick();
        chk("mis.pc", F_pc, 32'h40);
        chk("mis.err", {31'b0, F_misalign_err}, 32'd1);
        chk("mis.valid", {31'b0, D_valid}, 32'd0);
        F_redirect_target = 32'h80;
        tick();
        chk("mis2.pc", F_pc, 32'h80);
        chk("mis2.err", {31'b0, F_misalign_err}, 32'd1);
        F_redirect = 1'b0;

        // PC preload
        SYS_load = 1'b1;
        SYS_pc_val = 8'h05;
        tick();
        chk("load1.pc", F_pc, 32'h14);
        chk("load1.valid", {31'b0, D_valid}, 32'd0);
        tick();
        chk("load2.pc", F_pc, 32'h14);
        chk("load2.valid", {31'b0, D_valid}, 32'd0);
        SYS_load = 1'b0;
        tick();
        chk("load3.pc", F_pc, 32'h14);
        chk("load3.valid", {31'b0, D_valid}, 32'd0);
        tick();
        chk_d("postload", 32'h1000_0005, 32'h18, 1'b1);
        chk("postload.pc", F_pc, 32'h18);
        chk("postload.count", F_fetch_count, 32'd7);
        chk("postload.err", {31'b0, F_misalign_err}, 32'd1);

        // PC wrap at top of address space
        F_redirect = 1'b1;
        F_redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap0.pc", F_pc, 32'hFFFF_FFFC);
        F_redirect = 1'b0;
        tick();
        chk_d("wrap", 32'h1000_003F, 32'h0, 1'b1);
        chk("wrap.pc", F_pc, 32'h0);
        chk("wrap.count", F_fetch_count, 32'd8);

        // async reset between edges while in HOLD
        F_stall = 1'b1;
        tick();
        chk("hold.pc", F_pc, 32'h0);
        #1;
        SYS_reset = 1'b0;
        #1;
        chk("arst.pc", F_pc, 32'h0);
        chk_d("arst", 32'h0, 32'h0, 1'b0);
        chk("arst.count", F_fetch_count, 32'd0);
        chk("arst.err", {31'b0, F_misalign_err}, 32'd0);
        F_stall = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
